// File: rtl/memc_pkg.sv
// Shared types and sizing helpers for the memc_sweep cache storage array.
package memc_pkg;

  typedef enum logic [1:0] {INIT, IDLE, CLEAR, DUMP} memc_state_t;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

  function automatic int lanes_of(input int width, input int lane_w);
    return width / lane_w;
  endfunction

endpackage

// File: rtl/memc_sweep_if.sv
// Access, control and dump-stream bundle between a cache controller and one memc_sweep array.
interface memc_sweep_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 8,
  parameter int LANE_W = 8
);
  import memc_pkg::*;
  localparam int LANES = lanes_of(WIDTH, LANE_W);

  logic [ADDR_W-1:0] addr;
  logic [WIDTH-1:0]  data_in;
  logic              write;
  logic [LANES-1:0]  wr_mask;
  logic [WIDTH-1:0]  data_out;
  logic              ready;
  logic              clear_req;
  logic              dump_req;
  // Dump stream: an entry transfers on a cycle where dump_valid && dump_ready.
  // dump_valid never depends on dump_ready, and dump_addr/dump_data/dump_last
  // hold stable while dump_valid is high and dump_ready is low.
  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_addr;
  logic [WIDTH-1:0]  dump_data;
  logic              dump_last;
  logic              dump_done;
  memc_state_t       state;

  modport master (
    output addr, data_in, write, wr_mask, clear_req, dump_req, dump_ready,
    input  data_out, ready, dump_valid, dump_addr, dump_data, dump_last, dump_done, state
  );

  modport slave (
    input  addr, data_in, write, wr_mask, clear_req, dump_req, dump_ready,
    output data_out, ready, dump_valid, dump_addr, dump_data, dump_last, dump_done, state
  );

endinterface

// File: rtl/memc_sweep_ctrl.sv
// Sequencer for memc_sweep: INIT/CLEAR sweeps, dump stream handshake and the array write-port mux.
module memc_sweep_ctrl
  import memc_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 8,
  parameter int LANE_W = 8,
  localparam int LANES = lanes_of(WIDTH, LANE_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              write,
  input  logic [LANES-1:0]  wr_mask,
  input  logic              clear_req,
  input  logic              dump_req,
  input  logic              dump_ready,
  input  logic [WIDTH-1:0]  rd_dump_data,
  output logic [ADDR_W-1:0] rd_dump_addr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic [LANES-1:0]  mem_wmask,
  output logic              ready,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [WIDTH-1:0]  dump_data,
  output logic              dump_last,
  output logic              dump_done,
  output memc_state_t       state
);

  localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};

  logic [ADDR_W:0] ptr;
  logic [ADDR_W:0] ptr_nxt;
  logic            sweeping;

  assign ptr_nxt  = ptr + 1'b1;
  assign sweeping = (state == INIT) || (state == CLEAR);

  // In DUMP the array is read one entry ahead so the next entry is ready at the handshake edge.
  assign rd_dump_addr = (state == DUMP) ? ptr_nxt[ADDR_W-1:0] : '0;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = data_in;
    mem_wmask = wr_mask;
    if (sweeping) begin
      mem_we    = 1'b1;
      mem_waddr = ptr[ADDR_W-1:0];
      mem_wdata = '0;
      mem_wmask = '1;
    end else if (state == IDLE) begin
      mem_we = write;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= INIT;
      ptr        <= '0;
      ready      <= 1'b0;
      dump_valid <= 1'b0;
      dump_last  <= 1'b0;
      dump_done  <= 1'b0;
      dump_addr  <= '0;
      dump_data  <= '0;
    end else begin
      dump_done <= 1'b0;
      case (state)
        INIT, CLEAR: begin
          ptr <= ptr_nxt;
          if (ptr == LAST) begin
            state <= IDLE;
            ready <= 1'b1;
          end
        end
        IDLE: begin
          if (clear_req) begin
            state <= CLEAR;
            ptr   <= '0;
            ready <= 1'b0;
          end else if (dump_req) begin
            state      <= DUMP;
            ptr        <= '0;
            ready      <= 1'b0;
            dump_valid <= 1'b1;
            dump_addr  <= '0;
            dump_data  <= rd_dump_data;
            dump_last  <= 1'b0;
          end
        end
        DUMP: begin
          if (dump_valid && dump_ready) begin
            if (ptr == LAST) begin
              state      <= IDLE;
              ready      <= 1'b1;
              ptr        <= '0;
              dump_valid <= 1'b0;
              dump_last  <= 1'b0;
              dump_done  <= 1'b1;
            end else begin
              ptr       <= ptr_nxt;
              dump_addr <= ptr_nxt[ADDR_W-1:0];
              dump_data <= rd_dump_data;
              dump_last <= (ptr_nxt == LAST);
            end
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: rtl/memc_sweep.sv
// Parametrised cache storage array with lane-masked writes, hardware clear sweep and dump stream.
module memc_sweep
  import memc_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 8,
  parameter int LANE_W = 8,
  localparam int DEPTH = depth_of(ADDR_W),
  localparam int LANES = lanes_of(WIDTH, LANE_W)
) (
  input logic         clk,
  input logic         rst,
  memc_sweep_if.slave bus
);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WIDTH-1:0]  mem_wdata;
  logic [LANES-1:0]  mem_wmask;
  logic [ADDR_W-1:0] rd_dump_addr;
  logic [WIDTH-1:0]  rd_dump_data;

  memc_sweep_ctrl #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W),
    .LANE_W (LANE_W)
  ) u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .addr         (bus.addr),
    .data_in      (bus.data_in),
    .write        (bus.write),
    .wr_mask      (bus.wr_mask),
    .clear_req    (bus.clear_req),
    .dump_req     (bus.dump_req),
    .dump_ready   (bus.dump_ready),
    .rd_dump_data (rd_dump_data),
    .rd_dump_addr (rd_dump_addr),
    .mem_we       (mem_we),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .mem_wmask    (mem_wmask),
    .ready        (bus.ready),
    .dump_valid   (bus.dump_valid),
    .dump_addr    (bus.dump_addr),
    .dump_data    (bus.dump_data),
    .dump_last    (bus.dump_last),
    .dump_done    (bus.dump_done),
    .state        (bus.state)
  );

  // No reset on the array itself: the INIT sweep is what clears it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < LANES; k++) begin
        if (mem_wmask[k]) mem[mem_waddr][k*LANE_W +: LANE_W] <= mem_wdata[k*LANE_W +: LANE_W];
      end
    end
  end

  assign rd_dump_data = mem[rd_dump_addr];
  assign bus.data_out = (bus.write || !bus.ready) ? '0 : mem[bus.addr];

endmodule

// File: tb/tb_memc_sweep.sv
// Self-checking bench for memc_sweep: 16x256 bank plus a 1x16 dirty-array instance.
module tb_memc_sweep;
  import memc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rst_s;
  always #5 clk = ~clk;

  memc_sweep_if #(.WIDTH(16), .ADDR_W(8), .LANE_W(8)) bus ();
  memc_sweep_if #(.WIDTH(1),  .ADDR_W(4), .LANE_W(1)) sbus ();

  memc_sweep #(.WIDTH(16), .ADDR_W(8), .LANE_W(8)) dut   (.clk(clk), .rst(rst),   .bus(bus));
  memc_sweep #(.WIDTH(1),  .ADDR_W(4), .LANE_W(1)) dut_s (.clk(clk), .rst(rst_s), .bus(sbus));

  int checks = 0;
  int errors = 0;
  logic [15:0] model [256];
  logic [15:0] exp_q[$];

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
    logic [1:0]  mask;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d, input logic [1:0] m);
    logic [15:0] bm;
    bm = {{8{m[1]}}, {8{m[0]}}};
    return (old & ~bm) | (d & bm);
  endfunction

  task automatic wr(input logic [7:0] a, input logic [15:0] d, input logic [1:0] m);
    bus.addr = a; bus.data_in = d; bus.wr_mask = m; bus.write = 1'b1;
    #1;
    chk("rd_during_wr", bus.data_out, 16'h0);
    tick();
    bus.write = 1'b0;
    model[a] = merge(model[a], d, m);
  endtask

  task automatic rd_chk(input string name, input logic [7:0] a);
    bus.write = 1'b0; bus.addr = a;
    #1;
    chk(name, bus.data_out, model[a]);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.ready && n < 2000) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cyc, extra, done_cnt, last_bad, k;
    logic dv_seen, held;
    logic [15:0] hd, e;
    logic [7:0] ha;

    vecs[0] = '{8'h10, 16'hABCD, 2'b11, 16'hABCD};
    vecs[1] = '{8'h10, 16'h1200, 2'b10, 16'h12CD};
    vecs[2] = '{8'h10, 16'h0034, 2'b01, 16'h1234};
    vecs[3] = '{8'h10, 16'hFFFF, 2'b00, 16'h1234};
    vecs[4] = '{8'h20, 16'h5A5A, 2'b01, 16'h005A};
    vecs[5] = '{8'h20, 16'hC300, 2'b10, 16'hC35A};

    bus.addr = '0; bus.data_in = '0; bus.write = 1'b0; bus.wr_mask = '0;
    bus.clear_req = 1'b0; bus.dump_req = 1'b0; bus.dump_ready = 1'b0;
    sbus.addr = '0; sbus.data_in = '0; sbus.write = 1'b0; sbus.wr_mask = '0;
    sbus.clear_req = 1'b0; sbus.dump_req = 1'b0; sbus.dump_ready = 1'b0;
    for (int i = 0; i < 256; i++) model[i] = 16'h0;

    // Reset values
    rst = 1'b1; rst_s = 1'b1;
    tick(); tick();
    chk("rst_state", 32'(bus.state), 32'(INIT));
    chk("rst_ready", bus.ready, 0);
    chk("rst_dump_valid", bus.dump_valid, 0);
    chk("rst_dump_last", bus.dump_last, 0);
    chk("rst_dump_done", bus.dump_done, 0);
    chk("rst_dump_addr", bus.dump_addr, 0);
    chk("rst_dump_data", bus.dump_data, 0);
    chk("rst_data_out", bus.data_out, 0);

    // INIT length, with a write held during the sweep that must be ignored
    rst = 1'b0;
    bus.addr = 8'h05; bus.data_in = 16'hFFFF; bus.wr_mask = 2'b11; bus.write = 1'b1;
    wait_ready(n);
    bus.write = 1'b0;
    chk("init_cycles", n, 256);
    rd_chk("init_write_ignored", 8'h05);

    // Preload garbage, then reset sweep must clear everything
    for (int a = 0; a < 256; a++) wr(8'(a), 16'($urandom), 2'b11);
    rd_chk("garbage_readback", 8'(7));
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_ready_drop", bus.ready, 0);
    wait_ready(n);
    chk("reset_sweep_cycles", n, 256);
    for (int a = 0; a < 256; a++) model[a] = 16'h0;
    for (int a = 0; a < 256; a++) rd_chk("reset_sweep_zero", 8'(a));

    // Table-driven masked writes
    for (int i = 0; i < 6; i++) begin
      wr(vecs[i].addr, vecs[i].data, vecs[i].mask);
      bus.addr = vecs[i].addr;
      #1;
      chk("vec_readback", bus.data_out, vecs[i].exp);
    end

    // Random writes and reads against the model
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(1, 0) == 1) wr(8'($urandom), 16'($urandom), 2'($urandom));
      else rd_chk("rand_read", 8'($urandom));
    end

    // Dump with backpressure: entry i holds i
    for (int a = 0; a < 256; a++) wr(8'(a), 16'(a), 2'b11);
    exp_q.delete();
    for (int a = 0; a < 256; a++) exp_q.push_back(16'(a));
    bus.dump_req = 1'b1; tick(); bus.dump_req = 1'b0;
    chk("dump_first_valid", bus.dump_valid, 1);
    chk("dump_ready_low", bus.ready, 0);
    cyc = 0; extra = 0; done_cnt = 0; last_bad = 0; held = 1'b0; hd = '0; ha = '0;
    while (cyc < 2000 && extra < 4) begin
      bus.dump_ready = cyc[0];
      #1;
      if (held && bus.dump_valid) begin
        chk("dump_hold_data", bus.dump_data, hd);
        chk("dump_hold_addr", bus.dump_addr, ha);
      end
      held = 1'b0;
      if (bus.dump_valid && bus.dump_last && bus.dump_addr != 8'hFF) last_bad++;
      if (bus.dump_valid && !bus.dump_ready) begin
        held = 1'b1; hd = bus.dump_data; ha = bus.dump_addr;
      end
      if (bus.dump_valid && bus.dump_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("dump_addr", bus.dump_addr, e);
        chk("dump_data", bus.dump_data, e);
        chk("dump_last", bus.dump_last, (e == 16'd255));
      end
      if (bus.dump_done) begin
        done_cnt++;
        chk("done_ready", bus.ready, 1);
      end
      if (exp_q.size() == 0) extra++;
      tick();
      cyc++;
    end
    bus.dump_ready = 1'b0;
    chk("dump_all_entries", exp_q.size(), 0);
    chk("dump_done_count", done_cnt, 1);
    chk("dump_last_spurious", last_bad, 0);

    // Simultaneous clear and dump requests: clear wins
    bus.clear_req = 1'b1; bus.dump_req = 1'b1; tick();
    bus.clear_req = 1'b0; bus.dump_req = 1'b0;
    chk("clear_state", 32'(bus.state), 32'(CLEAR));
    n = 0; dv_seen = 1'b0;
    while (!bus.ready && n < 2000) begin
      if (bus.dump_valid) dv_seen = 1'b1;
      tick();
      n++;
    end
    chk("clear_cycles", n, 256);
    chk("clear_no_dump", dv_seen, 0);
    for (int a = 0; a < 256; a++) model[a] = 16'h0;
    for (int a = 0; a < 256; a++) rd_chk("clear_zero", 8'(a));

    // Reset in the middle of a dump
    for (int a = 0; a < 128; a++) wr(8'(a), 16'($urandom), 2'b11);
    bus.dump_req = 1'b1; tick(); bus.dump_req = 1'b0;
    bus.dump_ready = 1'b1;
    n = 0;
    while (bus.dump_addr != 8'd100 && n < 1000) begin
      tick();
      n++;
    end
    chk("middump_reach_100", bus.dump_addr, 100);
    chk("middump_data_100", bus.dump_data, model[100]);
    rst = 1'b1; tick(); rst = 1'b0; bus.dump_ready = 1'b0;
    chk("middump_valid_drop", bus.dump_valid, 0);
    n = 0; done_cnt = 0;
    while (!bus.ready && n < 2000) begin
      if (bus.dump_done) done_cnt++;
      tick();
      n++;
    end
    chk("middump_init_cycles", n, 256);
    chk("middump_no_done", done_cnt, 0);

    // Dirty-array configuration: WIDTH=1, LANE_W=1, ADDR_W=4
    rst_s = 1'b1; tick(); rst_s = 1'b0;
    n = 0;
    while (!sbus.ready && n < 200) begin
      tick();
      n++;
    end
    chk("small_init_cycles", n, 16);
    for (int a = 0; a < 16; a++) begin
      sbus.addr = 4'(a); sbus.data_in = 1'(a % 2); sbus.wr_mask = 1'b1; sbus.write = 1'b1;
      tick();
    end
    sbus.write = 1'b0;
    for (int a = 0; a < 16; a++) begin
      sbus.addr = 4'(a);
      #1;
      chk("small_read", sbus.data_out, a % 2);
    end
    sbus.dump_req = 1'b1; tick(); sbus.dump_req = 1'b0;
    sbus.dump_ready = 1'b1;
    k = 0;
    while (!sbus.dump_done && k < 100) begin
      if (sbus.dump_valid) begin
        chk("small_dump_addr", sbus.dump_addr, k);
        chk("small_dump_data", sbus.dump_data, k % 2);
        chk("small_dump_last", sbus.dump_last, (k == 15));
      end
      k++;
      tick();
    end
    sbus.dump_ready = 1'b0;
    chk("small_dump_cycles", k, 16);
    chk("small_done_ready", sbus.ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memc_sweep.md
# memc_sweep

Parametrised cache storage array for the Icache/Dcache data, tag and dirty arrays: configurable width, depth and write-lane granularity. Clearing is a hardware sweep of one entry per cycle, used both after reset and on demand. Contents are read out through a synthesizable valid/ready dump stream instead of a simulation-only file dump. Sits beneath the cache controller, one instance per data bank, tag array and dirty array.

## Interface
- WIDTH, 16: entry width in bits.
- ADDR_W, 8: address width; DEPTH = 2**ADDR_W entries.
- LANE_W, 8: write-mask granularity in bits. WIDTH must be a multiple of LANE_W; LANES = WIDTH/LANE_W.

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- addr  in  ADDR_W  access address.
- data_in  in  WIDTH  write data.
- write  in  1  write strobe.
- wr_mask  in  LANES  per-lane write enable; lane k covers bits [k*LANE_W +: LANE_W].
- data_out  out  WIDTH  combinational read data.
- ready  out  1  array accepts accesses (state IDLE).
- clear_req  in  1  start a clear sweep (sampled in IDLE only).
- dump_req  in  1  start a dump (sampled in IDLE only).
- dump_valid  out  1  dump entry available.
- dump_ready  in  1  consumer accepts the dump entry.
- dump_addr  out  ADDR_W  index of the current dump entry.
- dump_data  out  WIDTH  contents of the current dump entry.
- dump_last  out  1  current entry is DEPTH-1.
- dump_done  out  1  one-cycle pulse after the final dump handshake.

## Operation
States are INIT, IDLE, CLEAR and DUMP.

- **INIT**
  - Entered on rst from any state, including mid-sweep or mid-dump.
  - A sweep counter writes 0 to entry ptr each cycle, with ptr running 0..DEPTH-1.
  - Moves to IDLE after entry DEPTH-1 is cleared.
- **IDLE**
  - ready=1.
  - When write=1, lanes with wr_mask[k]=1 are written at the clock edge. Other lanes keep their value.
  - data_out = (write | !ready) ? 0 : mem[addr]. A read during a write returns 0.
  - clear_req=1 moves to CLEAR. dump_req=1 moves to DUMP.
  - If both are asserted, clear_req wins and the dump request is dropped.
  - A write in the same cycle as a request is still performed.
- **CLEAR**
  - Same sweep as INIT, then returns to IDLE.
- **DUMP**
  - ptr starts at 0. dump_data and dump_addr are registered from mem[ptr].
  - On each dump_valid & dump_ready handshake, ptr increments and the next entry is loaded.
  - dump_last=1 while dump_addr = DEPTH-1.
  - The handshake on the last entry returns to IDLE and pulses dump_done.
  - dump_valid stays asserted, with data held stable, until accepted.
- **Outside IDLE**
  - ready=0 and data_out=0.
  - write, clear_req and dump_req are ignored, not queued.
- ptr is ADDR_W+1 bits wide, so the terminal count DEPTH never aliases to 0.

## Timing
- Reset values, registered on the rst cycle:
  - state=INIT, ptr=0.
  - ready=0, dump_valid=0, dump_last=0, dump_done=0.
  - dump_addr=0, dump_data=0.
  - data_out=0.
- INIT and CLEAR each take exactly DEPTH cycles. ready rises on cycle DEPTH after rst deasserts, or after the clear_req edge.
- Write latency is 1 cycle: the new data is visible on data_out the cycle after the write edge.
- Read latency is 0 (combinational).
- DUMP: dump_valid=1 with entry 0 on the cycle after dump_req is accepted.
  - With dump_ready held at 1, the stream is one entry per cycle: DEPTH cycles total.
  - dump_done pulses on the cycle after the last handshake. ready=1 on that same cycle.
- dump_valid must not depend combinationally on dump_ready.

## Structure
- Package memc_pkg holds:
  - the state enum, memc_state_t {INIT, IDLE, CLEAR, DUMP};
  - the localparam helpers for DEPTH and LANES.
- Sub-module memc_sweep_ctrl holds the FSM, the ptr counter and the dump handshake. It drives the array write port (sweep clear vs. user write mux).
- The top level holds the storage array, lane masking and the read mux.

## Test plan
- **Reset sweep:** preload garbage, pulse rst.
  - ready=0 for 256 cycles, then 1.
  - Every addr reads 0.
  - write asserted during INIT has no effect.
- **Masked write:** write 0xABCD to addr 0x10 with mask 2'b11, then 0x1200 with mask 2'b10.
  - Reads back 0x12CD.
  - Read during the write cycle gives data_out=0.
- **Dump with backpressure:** write addr i = i for all i; dump_req; toggle dump_ready every other cycle.
  - Entries arrive 0..255 in order with data = i.
  - Data is held while stalled.
  - dump_last only on 255; dump_done pulses once.
- **Simultaneous requests:** clear_req and dump_req in the same IDLE cycle.
  - CLEAR runs; no dump_valid is ever seen.
  - All entries are 0 afterwards.
- **Reset mid-dump:** assert rst at entry 100.
  - dump_valid drops on the next cycle; INIT runs a full 256 cycles.
  - No dump_done.
- **Parameter sweep:** WIDTH=1, LANE_W=1, ADDR_W=4 (dirty-array configuration).
  - INIT is 16 cycles.
  - Write/read and a full dump work.
